// File: rtl/mdu_pkg.sv
// Shared MDU op-code encoding, default latencies and the start-op decode used by e_mdu and the hazard unit.
// Codes 9..12 (MADD family) decode as start ops only when MDU_MADD_EN is defined.
package mdu_pkg;

    localparam int MDUOP_W = 4;

    localparam logic [MDUOP_W-1:0] MDU_NONE  = 4'd0;
    localparam logic [MDUOP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [MDUOP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [MDUOP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [MDUOP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [MDUOP_W-1:0] MDU_MTHI  = 4'd5;
    localparam logic [MDUOP_W-1:0] MDU_MTLO  = 4'd6;
    localparam logic [MDUOP_W-1:0] MDU_MFHI  = 4'd7;
    localparam logic [MDUOP_W-1:0] MDU_MFLO  = 4'd8;
    localparam logic [MDUOP_W-1:0] MDU_MADD  = 4'd9;
    localparam logic [MDUOP_W-1:0] MDU_MADDU = 4'd10;
    localparam logic [MDUOP_W-1:0] MDU_MSUB  = 4'd11;
    localparam logic [MDUOP_W-1:0] MDU_MSUBU = 4'd12;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_start(input logic [MDUOP_W-1:0] op);
        logic s;
        s = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
`ifdef MDU_MADD_EN
        s = s || (op == MDU_MADD) || (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
        return s;
    endfunction

    function automatic logic is_div(input logic [MDUOP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result of an MDU start op: next {HI,LO} from op, operands and committed HI/LO.
// Divide by zero returns the committed HI/LO unchanged; MADD family only with MDU_MADD_EN.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [MDUOP_W-1:0] op_i,
    input  logic [31:0]        rs_i,
    input  logic [31:0]        rt_i,
    input  logic [31:0]        hi_i,
    input  logic [31:0]        lo_i,
    output logic [31:0]        hi_o,
    output logic [31:0]        lo_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    assign prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

    // Signed divide on magnitudes: 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    assign a_mag = rs_i[31] ? (32'd0 - rs_i) : rs_i;
    assign b_mag = rt_i[31] ? (32'd0 - rt_i) : rt_i;

    always_comb begin
        hi_o  = hi_i;
        lo_o  = lo_i;
        q_mag = '0;
        r_mag = '0;
        case (op_i)
            MDU_MULT:  {hi_o, lo_o} = prod_s;
            MDU_MULTU: {hi_o, lo_o} = prod_u;
            MDU_DIV: begin
                if (rt_i != 32'd0) begin
                    q_mag = a_mag / b_mag;
                    r_mag = a_mag % b_mag;
                    lo_o  = (rs_i[31] ^ rt_i[31]) ? (32'd0 - q_mag) : q_mag;
                    hi_o  = rs_i[31] ? (32'd0 - r_mag) : r_mag;
                end
            end
            MDU_DIVU: begin
                if (rt_i != 32'd0) begin
                    lo_o = rs_i / rt_i;
                    hi_o = rs_i % rt_i;
                end
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  {hi_o, lo_o} = {hi_i, lo_i} + prod_s;
            MDU_MADDU: {hi_o, lo_o} = {hi_i, lo_i} + prod_u;
            MDU_MSUB:  {hi_o, lo_o} = {hi_i, lo_i} - prod_s;
            MDU_MSUBU: {hi_o, lo_o} = {hi_i, lo_i} - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers, busy counter, mfhi/mflo read mux. Results commit
// MULT_CYCLES/DIV_CYCLES edges after an accepted start; starts and MTHI/MTLO while busy are dropped (MDU_MADD_EN adds MADD ops).
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        E_RS,
    input  logic [31:0]        E_RT,
    input  logic [MDUOP_W-1:0] E_MDUOp,
    output logic               E_MDU_Start,
    output logic               E_MDU_Busy,
    output logic [31:0]        E_MDU_Out
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic [31:0] arith_hi;
    logic [31:0] arith_lo;

    assign E_MDU_Start = is_start(E_MDUOp);
    assign E_MDU_Busy  = (cnt_q != 4'd0);

    mdu_arith u_arith (
        .op_i (E_MDUOp),
        .rs_i (E_RS),
        .rt_i (E_RT),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .hi_o (arith_hi),
        .lo_o (arith_lo)
    );

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        phi_d = phi_q;
        plo_d = plo_q;
        if (E_MDU_Busy) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end else if (E_MDU_Start) begin
            phi_d = arith_hi;
            plo_d = arith_lo;
            cnt_d = is_div(E_MDUOp) ? DIV_CNT : MULT_CNT;
        end else if (E_MDUOp == MDU_MTHI) begin
            hi_d = E_RS;
        end else if (E_MDUOp == MDU_MTLO) begin
            lo_d = E_RS;
        end
    end

    // Reads always see committed HI/LO, never the pending result.
    always_comb begin
        E_MDU_Out = '0;
        if (E_MDUOp == MDU_MFHI) begin
            E_MDU_Out = hi_q;
        end else if (E_MDUOp == MDU_MFLO) begin
            E_MDU_Out = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            phi_q <= '0;
            plo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: table of mult/div vectors plus hand sequences for reset, busy and divide-by-zero.
module tb_e_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] E_RS = '0;
    logic [31:0] E_RT = '0;
    logic [3:0]  E_MDUOp = '0;
    logic        E_MDU_Start;
    logic        E_MDU_Busy;
    logic [31:0] E_MDU_Out;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vt[8];

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .E_RS        (E_RS),
        .E_RT        (E_RT),
        .E_MDUOp     (E_MDUOp),
        .E_MDU_Start (E_MDU_Start),
        .E_MDU_Busy  (E_MDU_Busy),
        .E_MDU_Out   (E_MDU_Out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle per call: inputs change at negedge, outputs settle 1 time unit later.
    task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        E_MDUOp = op;
        E_RS    = rs;
        E_RT    = rt;
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (E_MDU_Busy === 1'b1 && n < 40) begin
            n++;
            drive(MDU_NONE, 32'd0, 32'd0);
        end
    endtask

    initial begin
        int n;

        vt[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vt[1] = '{MDU_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vt[2] = '{MDU_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        vt[3] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vt[4] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[5] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vt[6] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vt[7] = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};

        // Reset clears a previously written HI
        rst = 1'b0;
        drive(MDU_NONE, 32'd0, 32'd0);
        drive(MDU_NONE, 32'd0, 32'd0);
        rst = 1'b1;
        drive(MDU_MTHI, 32'h1234, 32'd0);
        drive(MDU_MFHI, 32'd0, 32'd0);
        chk("mthi_pre_reset", E_MDU_Out, 32'h1234);
        rst = 1'b0;
        drive(MDU_NONE, 32'd0, 32'd0);
        drive(MDU_MFHI, 32'd0, 32'd0);
        rst = 1'b1;
        chk("reset_busy", {31'd0, E_MDU_Busy}, 32'd0);
        chk("reset_hi", E_MDU_Out, 32'd0);
        drive(MDU_MFLO, 32'd0, 32'd0);
        chk("reset_lo", E_MDU_Out, 32'd0);
        drive(MDU_NONE, 32'd0, 32'd0);
        chk("none_out_zero", E_MDU_Out, 32'd0);

        // Table-driven multiply/divide vectors
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].op, vt[i].rs, vt[i].rt);
            chk($sformatf("v%0d_start", i), {31'd0, E_MDU_Start}, 32'd1);
            chk($sformatf("v%0d_idle", i), {31'd0, E_MDU_Busy}, 32'd0);
            drive(MDU_NONE, 32'd0, 32'd0);
            wait_idle(n);
            chk($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(vt[i].cyc));
            drive(MDU_MFHI, 32'd0, 32'd0);
            chk($sformatf("v%0d_hi", i), E_MDU_Out, vt[i].hi);
            drive(MDU_MFLO, 32'd0, 32'd0);
            chk($sformatf("v%0d_lo", i), E_MDU_Out, vt[i].lo);
        end

        // Divide by zero keeps HI/LO but still takes the full divide latency
        drive(MDU_MTHI, 32'd5, 32'd0);
        drive(MDU_MTLO, 32'd6, 32'd0);
        drive(MDU_DIVU, 32'd9, 32'd0);
        drive(MDU_NONE, 32'd0, 32'd0);
        wait_idle(n);
        chk("div0_busy_cycles", 32'(n), 32'd10);
        drive(MDU_MFHI, 32'd0, 32'd0);
        chk("div0_hi", E_MDU_Out, 32'd5);
        drive(MDU_MFLO, 32'd0, 32'd0);
        chk("div0_lo", E_MDU_Out, 32'd6);

        // Zero-latency MTLO, then starts and MTHI while busy are ignored
        drive(MDU_MTLO, 32'hCAFEF00D, 32'd0);
        drive(MDU_MFLO, 32'd0, 32'd0);
        chk("mtlo_mflo", E_MDU_Out, 32'hCAFEF00D);
        drive(MDU_MTHI, 32'h22222222, 32'd0);
        drive(MDU_MULT, 32'd2, 32'd3);
        drive(MDU_DIV, 32'd100, 32'd7);
        chk("start_ungated", {31'd0, E_MDU_Start}, 32'd1);
        chk("busy_after_start", {31'd0, E_MDU_Busy}, 32'd1);
        drive(MDU_MTHI, 32'hDEAD, 32'd0);
        drive(MDU_MFLO, 32'd0, 32'd0);
        chk("mflo_old_while_busy", E_MDU_Out, 32'hCAFEF00D);
        drive(MDU_MFHI, 32'd0, 32'd0);
        chk("mthi_ignored_busy", E_MDU_Out, 32'h22222222);
        drive(MDU_NONE, 32'd0, 32'd0);
        wait_idle(n);
        chk("busy_not_reloaded", 32'(4 + n), 32'd5);
        drive(MDU_MFHI, 32'd0, 32'd0);
        chk("busy_seq_hi", E_MDU_Out, 32'd0);
        drive(MDU_MFLO, 32'd0, 32'd0);
        chk("busy_seq_lo", E_MDU_Out, 32'd6);

        // Reset in busy cycle 4 of a divide aborts it with no later commit
        drive(MDU_MTHI, 32'hAAAA, 32'd0);
        drive(MDU_MTLO, 32'hBBBB, 32'd0);
        drive(MDU_DIV, 32'hFFFFFFF9, 32'd2);
        drive(MDU_NONE, 32'd0, 32'd0);
        drive(MDU_NONE, 32'd0, 32'd0);
        drive(MDU_NONE, 32'd0, 32'd0);
        drive(MDU_NONE, 32'd0, 32'd0);
        chk("abort_busy_c4", {31'd0, E_MDU_Busy}, 32'd1);
        rst = 1'b0;
        drive(MDU_MFHI, 32'd0, 32'd0);
        rst = 1'b1;
        chk("abort_busy_clr", {31'd0, E_MDU_Busy}, 32'd0);
        chk("abort_hi", E_MDU_Out, 32'd0);
        drive(MDU_MFLO, 32'd0, 32'd0);
        chk("abort_lo", E_MDU_Out, 32'd0);
        for (int k = 0; k < 12; k++) drive(MDU_NONE, 32'd0, 32'd0);
        drive(MDU_MFLO, 32'd0, 32'd0);
        chk("abort_no_commit_lo", E_MDU_Out, 32'd0);
        chk("abort_still_idle", {31'd0, E_MDU_Busy}, 32'd0);

`ifdef MDU_MADD_EN
        drive(MDU_MTHI, 32'd0, 32'd0);
        drive(MDU_MTLO, 32'hFFFFFFFF, 32'd0);
        drive(MDU_MADDU, 32'd1, 32'd1);
        chk("maddu_start", {31'd0, E_MDU_Start}, 32'd1);
        drive(MDU_NONE, 32'd0, 32'd0);
        wait_idle(n);
        chk("maddu_busy_cycles", 32'(n), 32'd5);
        drive(MDU_MFHI, 32'd0, 32'd0);
        chk("maddu_hi", E_MDU_Out, 32'd1);
        drive(MDU_MFLO, 32'd0, 32'd0);
        chk("maddu_lo", E_MDU_Out, 32'd0);
`else
        drive(MDU_MTHI, 32'h77, 32'd0);
        drive(MDU_MTLO, 32'h88, 32'd0);
        drive(MDU_MADDU, 32'd1, 32'd1);
        chk("op10_no_start", {31'd0, E_MDU_Start}, 32'd0);
        drive(MDU_MFHI, 32'd0, 32'd0);
        chk("op10_no_busy", {31'd0, E_MDU_Busy}, 32'd0);
        chk("op10_hi", E_MDU_Out, 32'h77);
        drive(MDU_MFLO, 32'd0, 32'd0);
        chk("op10_lo", E_MDU_Out, 32'h88);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. It consumes the operands and control that the D->E pipeline register delivers (E_RS, E_RT, E_MDUOp).
- Holds the architectural HI/LO registers and models multi-cycle mult/div latency with a busy counter.
- Drives a busy/start indication to the hazard unit so D-stage MDU instructions stall.
- Drives mfhi/mflo data into the E-stage result mux and forwarding network.

Parameters:
MULT_CYCLES, 5, cycles HI/LO stay busy after a mult/multu start (legal range 1..15).
DIV_CYCLES, 10, cycles HI/LO stay busy after a div/divu start (legal range 1..15).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-low reset; sampled on clk rising edge.
E_RS  input  32  forwarded rs operand.
E_RT  input  32  forwarded rt operand.
E_MDUOp  input  4  operation code from the pipeline register; encoding is in mdu_pkg.
E_MDU_Start  output  1  combinational; 1 when E_MDUOp is mult, multu, div or divu (or madd* with the option enabled).
E_MDU_Busy  output  1  registered; 1 while the latency counter is nonzero.
E_MDU_Out  output  32  combinational; HI for MFHI, LO for MFLO, else 0.

Behaviour:
- Op codes:
  - NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - Codes 9..12 are reserved for the optional feature.
  - Other codes act as NONE.
- Reset (rst==0 at an edge): HI=0, LO=0, counter=0, pending HI/LO=0, so E_MDU_Busy=0.
  - Reset mid-operation aborts the operation. No commit occurs.
- Start handshake:
  - A start op is accepted only when E_MDU_Busy==0.
  - On an accepted start edge:
    - Compute the result into pending_hi/pending_lo.
    - Load the counter with MULT_CYCLES or DIV_CYCLES.
- Counter:
  - Decrements by 1 each edge while nonzero.
  - On the edge where it goes 1->0, HI<=pending_hi and LO<=pending_lo.
  - Example with start in cycle 0 and N=MULT_CYCLES: Busy is high in cycles 1..N; new HI/LO are visible in cycle N+1.
- Hazard rule: the hazard unit stalls a D-stage MDU op when E_MDU_Start | E_MDU_Busy. E_MDU_Start itself is not gated by busy.
- Illegal use (defensive):
  - A start while Busy is ignored; the running operation is unaffected.
  - MTHI/MTLO while Busy are ignored.
  - MFHI/MFLO while Busy return the old committed HI/LO.
- Arithmetic:
  - MULT: {HI,LO} = signed 32x32 -> 64-bit product.
  - MULTU: unsigned 32x32 -> 64-bit product.
  - DIV: LO = signed quotient, truncated toward zero; HI = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (E_RT==0): the op still occupies DIV_CYCLES, but HI/LO are left unchanged at commit.
  - DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO (not busy): HI or LO <= E_RS at the edge, with zero latency. A following MFHI/MFLO in the next cycle sees the new value.
- E_MDU_Out is purely combinational from committed HI/LO. No bypass of pending values.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined, adds four ops:
  - MADD=9: {HI,LO} += signed product.
  - MADDU=10: {HI,LO} += unsigned product.
  - MSUB=11: {HI,LO} -= signed product.
  - MSUBU=12: {HI,LO} -= unsigned product.
- Each uses 64-bit wrap-around arithmetic against the committed {HI,LO} at the start edge.
- Each takes MULT_CYCLES and asserts E_MDU_Start.
- When undefined, codes 9..12 behave as NONE: no start, no state change.

Decomposition:
- mdu_pkg holds:
  - MDUOp width and op-code constants.
  - Default cycle counts.
  - An is_start(op) function shared by e_mdu and the hazard unit.
- One sub-module, mdu_arith: combinational computation of {pending_hi, pending_lo} from op, operands and current HI/LO, including divide-by-zero and overflow handling.
- Counter, HI/LO registers and handshake stay in e_mdu.

Test Plan:
- rst low for 2 edges after MTHI 0x1234 -> HI=0, LO=0, Busy=0, E_MDU_Out=0 for MFHI.
- MULT with RS=0xFFFFFFFE (-2), RT=3 at cycle 0 -> Busy=1 in cycles 1..5; MFHI/MFLO in cycle 6 give HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same operands with MULTU give HI=0x00000002, LO=0xFFFFFFFA.
- DIV with RS=-7, RT=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with RT=0 and HI=5, LO=6 beforehand -> Busy for 10 cycles, then HI=5, LO=6 unchanged.
- MTLO 0xCAFEF00D then MFLO in the next cycle -> E_MDU_Out=0xCAFEF00D. MTHI issued while Busy -> HI unchanged.
- DIV started, rst low at busy cycle 4 -> Busy=0, HI=LO=0 next cycle, and no later commit.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU with RS=1, RT=1 -> HI=1, LO=0. Without the macro, op 10 -> Start=0 and HI/LO unchanged.
